// File: rtl/hsv2rgb_pipe_if.sv
// Pixel stream bundle for the HSV->RGB converter: HSV in, RGB out.
// HSV2RGB_SYNC_EN adds hsync/vsync/de alongside each side of the stream.
interface hsv2rgb_pipe_if;
    logic [7:0] hsv_h_data;
    logic [7:0] hsv_s_data;
    logic [7:0] hsv_v_data;
    logic       hsv_valid;
    logic [7:0] rgb_r_data;
    logic [7:0] rgb_g_data;
    logic [7:0] rgb_b_data;
    logic       rgb_valid;
`ifdef HSV2RGB_SYNC_EN
    logic       hsv_hsync;
    logic       hsv_vsync;
    logic       hsv_de;
    logic       rgb_hsync;
    logic       rgb_vsync;
    logic       rgb_de;

    modport master (
        output hsv_h_data, hsv_s_data, hsv_v_data, hsv_valid,
        output hsv_hsync, hsv_vsync, hsv_de,
        input  rgb_r_data, rgb_g_data, rgb_b_data, rgb_valid,
        input  rgb_hsync, rgb_vsync, rgb_de
    );

    modport slave (
        input  hsv_h_data, hsv_s_data, hsv_v_data, hsv_valid,
        input  hsv_hsync, hsv_vsync, hsv_de,
        output rgb_r_data, rgb_g_data, rgb_b_data, rgb_valid,
        output rgb_hsync, rgb_vsync, rgb_de
    );
`else
    modport master (
        output hsv_h_data, hsv_s_data, hsv_v_data, hsv_valid,
        input  rgb_r_data, rgb_g_data, rgb_b_data, rgb_valid
    );

    modport slave (
        input  hsv_h_data, hsv_s_data, hsv_v_data, hsv_valid,
        output rgb_r_data, rgb_g_data, rgb_b_data, rgb_valid
    );
`endif
endinterface

// File: rtl/hsv2rgb_pipe.sv
// Streaming HSV->RGB converter, fixed 3-cycle latency, one pixel per clock.
// Define HSV2RGB_SYNC_EN to carry hsync/vsync/de through the pipeline.
module hsv2rgb_pipe (
    input  logic          clk,
    input  logic          resetn,
    hsv2rgb_pipe_if.slave io
);

    // Exact floor(x/255) for x <= 65025; sum cannot overflow 16 bits.
    function automatic logic [7:0] div255(input logic [15:0] x);
        return 8'((x + (x >> 8) + 16'd1) >> 8);
    endfunction

    logic [7:0]  hn;
    logic [4:0]  f;

    logic [7:0]  s1_kf_d,  s1_kf_q;
    logic [7:0]  s1_kt_d,  s1_kt_q;
    logic [7:0]  s1_ns_d,  s1_ns_q;
    logic [7:0]  s1_v_d,   s1_v_q;
    logic [2:0]  s1_sec_d, s1_sec_q;

    logic [15:0] s2_p_d,   s2_p_q;
    logic [15:0] s2_q_d,   s2_q_q;
    logic [15:0] s2_t_d,   s2_t_q;
    logic [7:0]  s2_v_d,   s2_v_q;
    logic [2:0]  s2_sec_d, s2_sec_q;

    logic [7:0]  p, q, t;
    logic [7:0]  r_d, r_q;
    logic [7:0]  g_d, g_q;
    logic [7:0]  b_d, b_q;
    logic [2:0]  vld_d, vld_q;

    always_comb begin
        hn = (io.hsv_h_data >= 8'd192) ? io.hsv_h_data - 8'd192
                                       : io.hsv_h_data;
        f  = hn[4:0];

        s1_sec_d = hn[7:5];
        s1_kf_d  = 8'(({6'd0, io.hsv_s_data} * {9'd0, f}) >> 5);
        s1_kt_d  = 8'(({6'd0, io.hsv_s_data}
                       * (14'd32 - {9'd0, f})) >> 5);
        s1_ns_d  = 8'd255 - io.hsv_s_data;
        s1_v_d   = io.hsv_v_data;

        s2_p_d   = {8'd0, s1_v_q} * {8'd0, s1_ns_q};
        s2_q_d   = {8'd0, s1_v_q} * {8'd0, 8'd255 - s1_kf_q};
        s2_t_d   = {8'd0, s1_v_q} * {8'd0, 8'd255 - s1_kt_q};
        s2_v_d   = s1_v_q;
        s2_sec_d = s1_sec_q;

        p = div255(s2_p_q);
        q = div255(s2_q_q);
        t = div255(s2_t_q);

        r_d = s2_v_q;
        g_d = t;
        b_d = p;
        case (s2_sec_q)
            3'd1: begin r_d = q;      g_d = s2_v_q; b_d = p;      end
            3'd2: begin r_d = p;      g_d = s2_v_q; b_d = t;      end
            3'd3: begin r_d = p;      g_d = q;      b_d = s2_v_q; end
            3'd4: begin r_d = t;      g_d = p;      b_d = s2_v_q; end
            3'd5: begin r_d = s2_v_q; g_d = p;      b_d = q;      end
            default: ;
        endcase

        vld_d = {vld_q[1:0], io.hsv_valid};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_kf_q  <= '0;
            s1_kt_q  <= '0;
            s1_ns_q  <= '0;
            s1_v_q   <= '0;
            s1_sec_q <= '0;
            s2_p_q   <= '0;
            s2_q_q   <= '0;
            s2_t_q   <= '0;
            s2_v_q   <= '0;
            s2_sec_q <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            vld_q    <= '0;
        end else begin
            s1_kf_q  <= s1_kf_d;
            s1_kt_q  <= s1_kt_d;
            s1_ns_q  <= s1_ns_d;
            s1_v_q   <= s1_v_d;
            s1_sec_q <= s1_sec_d;
            s2_p_q   <= s2_p_d;
            s2_q_q   <= s2_q_d;
            s2_t_q   <= s2_t_d;
            s2_v_q   <= s2_v_d;
            s2_sec_q <= s2_sec_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            vld_q    <= vld_d;
        end
    end

    assign io.rgb_r_data = r_q;
    assign io.rgb_g_data = g_q;
    assign io.rgb_b_data = b_q;
    assign io.rgb_valid  = vld_q[2];

`ifdef HSV2RGB_SYNC_EN
    logic [2:0] hs_d, hs_q;
    logic [2:0] vs_d, vs_q;
    logic [2:0] de_d, de_q;

    always_comb begin
        hs_d = {hs_q[1:0], io.hsv_hsync};
        vs_d = {vs_q[1:0], io.hsv_vsync};
        de_d = {de_q[1:0], io.hsv_de};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_q <= '0;
            vs_q <= '0;
            de_q <= '0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
        end
    end

    assign io.rgb_hsync = hs_q[2];
    assign io.rgb_vsync = vs_q[2];
    assign io.rgb_de    = de_q[2];
`endif

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Self-checking bench for hsv2rgb_pipe against an arithmetic HSV->RGB model.
// Build with HSV2RGB_SYNC_EN defined to also exercise the sync/de path.
module tb_hsv2rgb_pipe;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hsv2rgb_pipe_if bus();

    hsv2rgb_pipe dut (
        .clk    (clk),
        .resetn (resetn),
        .io     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [23:0] rgb;
        logic [2:0]  sy;
    } exp_t;

    // Reference: plain integer HSV->RGB with floor division.
    function automatic logic [23:0] ref_rgb(int h, int s, int v);
        int hn, sec, f, kf, kt, p, q, t, r, g, b;
        hn  = h % 192;
        sec = hn / 32;
        f   = hn % 32;
        kf  = (s * f) / 32;
        kt  = (s * (32 - f)) / 32;
        p   = (v * (255 - s)) / 255;
        q   = (v * (255 - kf)) / 255;
        t   = (v * (255 - kt)) / 255;
        case (sec)
            0: begin r = v; g = t; b = p; end
            1: begin r = q; g = v; b = p; end
            2: begin r = p; g = v; b = t; end
            3: begin r = p; g = q; b = v; end
            4: begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [23:0] out_rgb();
        return {bus.rgb_r_data, bus.rgb_g_data, bus.rgb_b_data};
    endfunction

    task automatic drive(input int h, input int s, input int v,
                         input logic vld);
        bus.hsv_h_data = 8'(h);
        bus.hsv_s_data = 8'(s);
        bus.hsv_v_data = 8'(v);
        bus.hsv_valid  = vld;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        drive(10, 20, 30, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rgb_valid !== 1'b0 || out_rgb() !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b rgb=%h expected 0 000000",
                     bus.rgb_valid, out_rgb());
        end
        resetn = 1'b1;
        drive(0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rgb_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release[%0d]: valid=%b expected 0",
                         k, bus.rgb_valid);
            end
        end
    endtask

    task automatic test_primaries;
        int          th[7] = '{0, 64, 128, 16, 48, 96, 160};
        logic [23:0] te[7] = '{24'hFF0000, 24'h00FF00, 24'h0000FF,
                               24'hFF8000, 24'h80FF00, 24'h00FFFF,
                               24'hFF00FF};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(th[i], 255, 255, 1'b1);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (k == 1) drive(0, 0, 0, 1'b0);
                checks++;
                if (bus.rgb_valid !== (k == 3)) begin
                    errors++;
                    $display("FAIL primary_valid h=%0d k=%0d: got %b expected %b",
                             th[i], k, bus.rgb_valid, (k == 3));
                end
                if (k == 3) begin
                    checks++;
                    if (out_rgb() !== te[i]) begin
                        errors++;
                        $display("FAIL primary_rgb h=%0d: got %h expected %h",
                                 th[i], out_rgb(), te[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_gray;
        for (int i = 0; i < 195; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                checks++;
                if (bus.rgb_valid !== 1'b1 || out_rgb() !== 24'hC8C8C8) begin
                    errors++;
                    $display("FAIL gray h=%0d: valid=%b rgb=%h expected 1 c8c8c8",
                             i - 3, bus.rgb_valid, out_rgb());
                end
            end
            if (i < 192) drive(i, 0, 200, 1'b1);
            else         drive(0, 0, 0, 1'b0);
        end
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                checks++;
                if (bus.rgb_valid !== 1'b1 || out_rgb() !== 24'h0) begin
                    errors++;
                    $display("FAIL black[%0d]: valid=%b rgb=%h expected 1 000000",
                             i - 3, bus.rgb_valid, out_rgb());
                end
            end
            if (i < 32) drive($urandom_range(255), $urandom_range(255), 0, 1'b1);
            else        drive(0, 0, 0, 1'b0);
        end
    endtask

    task automatic test_valid_gaps;
        logic        pat[7] = '{1, 1, 0, 1, 0, 0, 1};
        logic [23:0] ex[7];
        int          h, s, v;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                checks++;
                if (bus.rgb_valid !== pat[i-3]) begin
                    errors++;
                    $display("FAIL gap_valid[%0d]: got %b expected %b",
                             i - 3, bus.rgb_valid, pat[i-3]);
                end
                if (pat[i-3]) begin
                    checks++;
                    if (out_rgb() !== ex[i-3]) begin
                        errors++;
                        $display("FAIL gap_rgb[%0d]: got %h expected %h",
                                 i - 3, out_rgb(), ex[i-3]);
                    end
                end
            end
            if (i < 7) begin
                h = 20 + 25 * i;
                s = 100 + 20 * i;
                v = 90 + 15 * i;
                ex[i] = ref_rgb(h, s, v);
                drive(h, s, v, pat[i]);
            end else begin
                drive(0, 0, 0, 1'b0);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] ex;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive($urandom_range(191), $urandom_range(255),
                  64 + $urandom_range(191), 1'b1);
        end
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.rgb_valid !== 1'b0 || out_rgb() !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b rgb=%h expected 0 000000",
                     bus.rgb_valid, out_rgb());
        end
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rgb_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale[%0d]: valid=%b expected 0",
                         k, bus.rgb_valid);
            end
        end
        ex = ref_rgb(40, 200, 180);
        drive(40, 200, 180, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 0, 0, 1'b0);
        end
        checks++;
        if (bus.rgb_valid !== 1'b1 || out_rgb() !== ex) begin
            errors++;
            $display("FAIL reset_first: valid=%b rgb=%h expected 1 %h",
                     bus.rgb_valid, out_rgb(), ex);
        end
    endtask

    task automatic test_random;
        exp_t sb[$];
        exp_t e;
        int   h, s, v;
        logic vld;
        for (int i = 0; i < 10003; i++) begin
            @(negedge clk);
            if (sb.size() == 3) begin
                e = sb.pop_front();
                checks++;
                if (bus.rgb_valid !== e.vld) begin
                    errors++;
                    $display("FAIL rand_valid[%0d]: got %b expected %b",
                             i, bus.rgb_valid, e.vld);
                end
                if (e.vld) begin
                    checks++;
                    if (out_rgb() !== e.rgb) begin
                        errors++;
                        $display("FAIL rand_rgb[%0d]: got %h expected %h",
                                 i, out_rgb(), e.rgb);
                    end
                end
            end
            h   = $urandom_range(255);
            s   = $urandom_range(255);
            v   = $urandom_range(255);
            vld = ($urandom_range(4) != 0);
            e.vld = vld;
            e.rgb = ref_rgb(h, s, v);
            e.sy  = 3'b000;
            sb.push_back(e);
            drive(h, s, v, vld);
        end
        drive(0, 0, 0, 1'b0);
    endtask

`ifdef HSV2RGB_SYNC_EN
    task automatic test_sync;
        exp_t       sb[$];
        exp_t       e;
        int         h, s, v;
        logic [2:0] sy;
        logic [2:0] got;
        for (int i = 0; i < 203; i++) begin
            @(negedge clk);
            if (sb.size() == 3) begin
                e   = sb.pop_front();
                got = {bus.rgb_hsync, bus.rgb_vsync, bus.rgb_de};
                checks++;
                if (got !== e.sy || bus.rgb_valid !== e.vld
                    || out_rgb() !== e.rgb) begin
                    errors++;
                    $display("FAIL sync[%0d]: got %b/%b/%h expected %b/%b/%h",
                             i, got, bus.rgb_valid, out_rgb(),
                             e.sy, e.vld, e.rgb);
                end
            end
            h  = $urandom_range(191);
            s  = $urandom_range(255);
            v  = $urandom_range(255);
            sy = 3'($urandom_range(7));
            e.vld = 1'b1;
            e.rgb = ref_rgb(h, s, v);
            e.sy  = sy;
            sb.push_back(e);
            drive(h, s, v, 1'b1);
            bus.hsv_hsync = sy[2];
            bus.hsv_vsync = sy[1];
            bus.hsv_de    = sy[0];
        end
        drive(0, 0, 0, 1'b0);
        bus.hsv_hsync = 1'b0;
        bus.hsv_vsync = 1'b0;
        bus.hsv_de    = 1'b0;
    endtask
`endif

    initial begin
        drive(0, 0, 0, 1'b0);
`ifdef HSV2RGB_SYNC_EN
        bus.hsv_hsync = 1'b0;
        bus.hsv_vsync = 1'b0;
        bus.hsv_de    = 1'b0;
`endif
        test_reset();
        test_primaries();
        test_gray();
        test_valid_gaps();
        test_reset_mid();
        test_random();
`ifdef HSV2RGB_SYNC_EN
        test_sync();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
